pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage F/D/E/M/W core. It inspects the instruction words in D, E, M and W and issues stall, bubble, flush and freeze controls to the pipeline registers, then tracks its mode in a small FSM. The datapath has no forwarding, and the register file writes on the falling edge in W. D may therefore read a result produced in W in the same cycle, but must stall on producers in E or M. It also keeps saturating performance counters.

## Interface
- no parameters
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous, active-low reset
- IR_D  in  32  instruction in decode
- IR_E  in  32  instruction in execute
- IR_M  in  32  instruction in memory
- redirect_E  in  1  taken BEQ or JMP resolved in E this cycle
- mem_busy  in  1  data memory not ready; whole pipe must hold
- stall_F  out  1  hold PC
- stall_D  out  1  hold IF/ID register
- bubble_E  out  1  load NOP (32'h0) into ID/EX
- flush_D  out  1  load NOP into IF/ID
- freeze  out  1  hold every stage register, including EX/MEM and MEM/WB
- pc_redirect  out  1  PC mux selects branch/jump target
- state  out  2  00 RUN, 01 STALL, 10 HOLD
- stall_cnt  out  16  data-hazard stall cycles, saturating at 16'hFFFF
- flush_cnt  out  16  redirects taken, saturating at 16'hFFFF

## Operation
- Writer predicate: op[5:3]==000 with op!=000000 (ALU), or op==001001 (LOAD). The destination is IR[25:21]. R0 is an ordinary register with no special case.
- D source registers:
  - NOP 000000: none
  - JMP 001011: none
  - ALU: IR_D[20:16] and IR_D[15:11]
  - LOAD: IR_D[20:16] only
  - every other opcode (BEQ, store, immediates): IR_D[20:16] and IR_D[25:21]
- hazard = any valid D source equals the destination of a writer in E or in M. W is never checked.
- Per-cycle priority: mem_busy, then redirect_E, then hazard.
  - mem_busy=1: freeze=1, stall_F=1, stall_D=1. All other outputs are 0. A pending redirect_E stays asserted upstream and is acted on in the first cycle with mem_busy=0.
  - redirect_E=1: pc_redirect=1, flush_D=1, bubble_E=1. Both wrong-path instructions are killed. The hazard is ignored that cycle, even if present.
  - hazard=1: stall_F=1, stall_D=1, bubble_E=1.
  - otherwise all controls are 0.
- Control outputs are combinational from the current inputs, so they act in the same cycle. The state register records the mode of the current cycle for observation and counting.
- FSM next state, evaluated every posedge:
  - mem_busy: HOLD
  - else hazard and not redirect_E: STALL
  - else: RUN
  - Legal transitions: RUN↔STALL, RUN↔HOLD, STALL↔HOLD. STALL goes to RUN when the producer reaches W, or when a redirect arrives. HOLD goes to STALL if a hazard is still pending when mem_busy drops.
- Counters:
  - stall_cnt increments on every posedge where the hazard branch won, with no mem_busy and no redirect_E.
  - flush_cnt increments on every posedge where redirect_E=1 and mem_busy=0.
  - Both counters saturate and never wrap.
- A hazard already handled as a stall is not double-counted during a HOLD cycle.

## Timing
- Reset, asynchronous on rst_n=0: state=RUN, stall_cnt=0, flush_cnt=0. During reset, controls follow the inputs combinationally, except that pc_redirect, flush_D and bubble_E are forced to 0.
- Latency: zero cycles from inputs to controls; one cycle from inputs to state and counters.
- ALU producer in E, consumer in D: 2 stall cycles (E then M). Producer in M: 1 stall cycle. Producer in W: 0 stall cycles.
- LOAD with a dependent consumer immediately behind it: 2 stall cycles, the same as ALU.
- Redirect: 1 cycle of pc_redirect, and 2 instructions squashed.
- Reset deasserted mid-hazard: the FSM starts in RUN. It enters STALL on the next posedge if the hazard is still present.

## Test plan
- ALU r3←r1,r2 followed directly by ALU r5←r3,r4:
  - stall_F/stall_D/bubble_E high for exactly 2 cycles
  - state RUN→STALL→STALL→RUN
  - stall_cnt=2
- Producer writes r7; two independent instructions follow; then a consumer of r7 (producer already in W): no stall, stall_cnt=0.
- BEQ in D reads r4 (IR_D[25:21]) while M holds a LOAD to r4: 1 stall cycle. A store using r4 in [25:21] gives the same result.
- redirect_E=1 in the same cycle as a hazard:
  - pc_redirect=flush_D=bubble_E=1 and stall_F=0
  - flush_cnt=1, stall_cnt unchanged, state RUN
- mem_busy high for 3 cycles while redirect_E is held:
  - freeze=1 for 3 cycles, state HOLD, flush_cnt=0 during the hold
  - on release: pc_redirect=1 for 1 cycle, flush_cnt=1
- Force stall_cnt to 16'hFFFE, then run 3 hazard cycles: the count ends at 16'hFFFF. Asserting rst_n=0 mid-stall clears both counters and the state immediately.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Control bundle between the pipeline datapath and the hazard controller.
// The datapath side drives the instruction words and pipe events, and the controller returns the stage controls and status.
interface pipe_hazard_ctrl_if;
    logic [31:0] IR_D;
    logic [31:0] IR_E;
    logic [31:0] IR_M;
    logic        redirect_E;
    logic        mem_busy;
    logic        stall_F;
    logic        stall_D;
    logic        bubble_E;
    logic        flush_D;
    logic        freeze;
    logic        pc_redirect;
    logic [1:0]  state;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    modport master (
        output IR_D, IR_E, IR_M, redirect_E, mem_busy,
        input  stall_F, stall_D, bubble_E, flush_D, freeze, pc_redirect,
        input  state, stall_cnt, flush_cnt
    );

    modport slave (
        input  IR_D, IR_E, IR_M, redirect_E, mem_busy,
        output stall_F, stall_D, bubble_E, flush_D, freeze, pc_redirect,
        output state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the F/D/E/M/W pipe: stall, bubble, flush, freeze and PC redirect.
// Latency: controls are combinational (0 cycles); state and counters register 1 cycle later.
// Backpressure: mem_busy freezes the whole pipe and overrides any redirect or data hazard.
module pipe_hazard_ctrl (
    input  logic               clk,
    input  logic               rst_n,
    pipe_hazard_ctrl_if.slave  bus
);
    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_STALL = 2'b01;
    localparam logic [1:0] ST_HOLD  = 2'b10;

    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_LOAD = 6'b001001;
    localparam logic [5:0] OP_JMP  = 6'b001011;

    logic [5:0]  w_op_d, w_op_e, w_op_m;
    logic [4:0]  w_dst_e, w_dst_m;
    logic [4:0]  w_src1, w_src2;
    logic        w_src1_vld, w_src2_vld;
    logic        w_alu_d, w_wr_e, w_wr_m;
    logic        w_hit_e, w_hit_m, w_hazard;
    logic        w_stall_f, w_stall_d, w_bubble_e, w_flush_d, w_freeze, w_pc_redirect;
    logic [1:0]  w_state_nxt;
    logic [1:0]  r_state;
    logic [15:0] r_stall_cnt, r_flush_cnt;

    assign w_op_d  = bus.IR_D[31:26];
    assign w_op_e  = bus.IR_E[31:26];
    assign w_op_m  = bus.IR_M[31:26];
    assign w_dst_e = bus.IR_E[25:21];
    assign w_dst_m = bus.IR_M[25:21];

    assign w_alu_d = (w_op_d[5:3] == 3'b000) && (w_op_d != OP_NOP);
    assign w_wr_e  = ((w_op_e[5:3] == 3'b000) && (w_op_e != OP_NOP)) || (w_op_e == OP_LOAD);
    assign w_wr_m  = ((w_op_m[5:3] == 3'b000) && (w_op_m != OP_NOP)) || (w_op_m == OP_LOAD);

    // Source 2 is rt for ALU ops and the [25:21] field for branches, stores and immediates.
    assign w_src1     = bus.IR_D[20:16];
    assign w_src2     = w_alu_d ? bus.IR_D[15:11] : bus.IR_D[25:21];
    assign w_src1_vld = (w_op_d != OP_NOP) && (w_op_d != OP_JMP);
    assign w_src2_vld = w_src1_vld && (w_op_d != OP_LOAD);

    assign w_hit_e = w_wr_e && ((w_src1_vld && (w_src1 == w_dst_e)) ||
                                (w_src2_vld && (w_src2 == w_dst_e)));
    assign w_hit_m = w_wr_m && ((w_src1_vld && (w_src1 == w_dst_m)) ||
                                (w_src2_vld && (w_src2 == w_dst_m)));
    assign w_hazard = w_hit_e || w_hit_m;

    always_comb begin
        w_stall_f     = 1'b0;
        w_stall_d     = 1'b0;
        w_bubble_e    = 1'b0;
        w_flush_d     = 1'b0;
        w_freeze      = 1'b0;
        w_pc_redirect = 1'b0;
        if (bus.mem_busy) begin
            w_freeze  = 1'b1;
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
        end else if (bus.redirect_E) begin
            w_pc_redirect = 1'b1;
            w_flush_d     = 1'b1;
            w_bubble_e    = 1'b1;
        end else if (w_hazard) begin
            w_stall_f  = 1'b1;
            w_stall_d  = 1'b1;
            w_bubble_e = 1'b1;
        end
    end

    // Controls that load or steer the pipe are held off while reset is asserted.
    assign bus.stall_F     = w_stall_f;
    assign bus.stall_D     = w_stall_d;
    assign bus.freeze      = w_freeze;
    assign bus.bubble_E    = w_bubble_e    & rst_n;
    assign bus.flush_D     = w_flush_d     & rst_n;
    assign bus.pc_redirect = w_pc_redirect & rst_n;

    always_comb begin
        w_state_nxt = ST_RUN;
        if (bus.mem_busy) begin
            w_state_nxt = ST_HOLD;
        end else if (w_hazard && !bus.redirect_E) begin
            w_state_nxt = ST_STALL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            if (!bus.mem_busy && !bus.redirect_E && w_hazard && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (!bus.mem_busy && bus.redirect_E && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign bus.state     = r_state;
    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl; expected results are queued at drive time and checked by a negedge monitor.
module tb_pipe_hazard_ctrl;
    localparam logic [5:0] OP_ALU   = 6'b000001;
    localparam logic [5:0] OP_LOAD  = 6'b001001;
    localparam logic [5:0] OP_JMP   = 6'b001011;
    localparam logic [5:0] OP_BEQ   = 6'b010000;
    localparam logic [5:0] OP_STORE = 6'b101011;
    localparam logic [5:0] OP_NOP   = 6'b000000;

    // Control order: {stall_F, stall_D, bubble_E, flush_D, freeze, pc_redirect}
    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_HAZ  = 6'b111000;
    localparam logic [5:0] C_RED  = 6'b001101;
    localparam logic [5:0] C_BUSY = 6'b110010;
    localparam logic [5:0] C_RSTH = 6'b110000;

    localparam logic [1:0] RUN = 2'b00, STL = 2'b01, HLD = 2'b10;

    typedef struct {
        int          id;
        logic [5:0]  ctl;
        logic [1:0]  st;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    int   vid;
    exp_t exp_q[$];

    pipe_hazard_ctrl_if bus();

    pipe_hazard_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] a,
                                       input logic [4:0] b, input logic [4:0] c);
        return {op, a, b, c, 11'd0};
    endfunction

    task automatic cmp(input int id, input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL v%0d %s: got %h, expected %h", id, nm, act, exp);
    endtask

    task automatic step(input logic r, input logic [31:0] d, input logic [31:0] e, input logic [31:0] m,
                        input logic red, input logic busy, input logic [5:0] ctl,
                        input logic [1:0] st, input logic [15:0] sc, input logic [15:0] fc);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n          = r;
        bus.IR_D       = d;
        bus.IR_E       = e;
        bus.IR_M       = m;
        bus.redirect_E = red;
        bus.mem_busy   = busy;
        x.id = vid; x.ctl = ctl; x.st = st; x.sc = sc; x.fc = fc;
        exp_q.push_back(x);
        vid++;
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (exp_q.size() != 0) begin
            x = exp_q.pop_front();
            cmp(x.id, "ctl", {10'd0, bus.stall_F, bus.stall_D, bus.bubble_E, bus.flush_D,
                              bus.freeze, bus.pc_redirect}, {10'd0, x.ctl});
            cmp(x.id, "state", {14'd0, bus.state}, {14'd0, x.st});
            cmp(x.id, "stall_cnt", bus.stall_cnt, x.sc);
            cmp(x.id, "flush_cnt", bus.flush_cnt, x.fc);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout: bench did not complete, %0d checks pending", exp_q.size());
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] p3, c3, x8, x12, c7, beq4, st4, ld4, ld6, jmp3, stn3, nop3, c0, p0;
        n_checks = 0; n_pass = 0; vid = 0;
        rst_n = 1'b0;
        bus.IR_D = '0; bus.IR_E = '0; bus.IR_M = '0;
        bus.redirect_E = 1'b0; bus.mem_busy = 1'b0;

        p3   = mk(OP_ALU, 5'd3, 5'd1, 5'd2);
        c3   = mk(OP_ALU, 5'd5, 5'd3, 5'd4);
        x8   = mk(OP_ALU, 5'd8, 5'd9, 5'd10);
        x12  = mk(OP_ALU, 5'd12, 5'd9, 5'd10);
        c7   = mk(OP_ALU, 5'd11, 5'd7, 5'd7);
        beq4 = mk(OP_BEQ, 5'd4, 5'd1, 5'd0);
        st4  = mk(OP_STORE, 5'd4, 5'd1, 5'd0);
        ld4  = mk(OP_LOAD, 5'd4, 5'd2, 5'd0);
        ld6  = mk(OP_LOAD, 5'd6, 5'd1, 5'd3);
        jmp3 = mk(OP_JMP, 5'd3, 5'd3, 5'd3);
        stn3 = mk(OP_STORE, 5'd3, 5'd0, 5'd0);
        nop3 = mk(OP_NOP, 5'd3, 5'd0, 5'd0);
        c0   = mk(OP_ALU, 5'd1, 5'd0, 5'd2);
        p0   = mk(OP_ALU, 5'd0, 5'd5, 5'd6);

        //    rst  D     E      M      red   busy  ctl     st   sc        fc
        step(0, c3,   p3,   '0,    1'b0, 1'b0, C_RSTH, RUN, 16'd0,    16'd0);
        // ALU producer directly followed by its consumer: two stall cycles
        step(1, p3,   '0,   '0,    1'b0, 1'b0, C_NONE, RUN, 16'd0,    16'd0);
        step(1, c3,   p3,   '0,    1'b0, 1'b0, C_HAZ,  RUN, 16'd0,    16'd0);
        step(1, c3,   '0,   p3,    1'b0, 1'b0, C_HAZ,  STL, 16'd1,    16'd0);
        step(1, c3,   '0,   '0,    1'b0, 1'b0, C_NONE, STL, 16'd2,    16'd0);
        step(1, '0,   c3,   '0,    1'b0, 1'b0, C_NONE, RUN, 16'd2,    16'd0);
        // producer of r7 already in W
        step(1, c7,   x8,   x12,   1'b0, 1'b0, C_NONE, RUN, 16'd2,    16'd0);
        // BEQ and store reading r4 via [25:21] behind a LOAD to r4 in M
        step(1, beq4, '0,   ld4,   1'b0, 1'b0, C_HAZ,  RUN, 16'd2,    16'd0);
        step(1, beq4, '0,   '0,    1'b0, 1'b0, C_NONE, STL, 16'd3,    16'd0);
        step(1, st4,  '0,   ld4,   1'b0, 1'b0, C_HAZ,  RUN, 16'd3,    16'd0);
        step(1, '0,   '0,   '0,    1'b0, 1'b0, C_NONE, STL, 16'd4,    16'd0);
        // source decode and writer predicate negatives, then R0 as ordinary register
        step(1, ld6,  p3,   '0,    1'b0, 1'b0, C_NONE, RUN, 16'd4,    16'd0);
        step(1, jmp3, p3,   p3,    1'b0, 1'b0, C_NONE, RUN, 16'd4,    16'd0);
        step(1, c3,   stn3, nop3,  1'b0, 1'b0, C_NONE, RUN, 16'd4,    16'd0);
        step(1, c0,   p0,   '0,    1'b0, 1'b0, C_HAZ,  RUN, 16'd4,    16'd0);
        // redirect beats a simultaneous hazard
        step(1, c0,   p0,   '0,    1'b1, 1'b0, C_RED,  STL, 16'd5,    16'd0);
        step(1, '0,   '0,   '0,    1'b0, 1'b0, C_NONE, RUN, 16'd5,    16'd1);
        // mem_busy for 3 cycles with redirect held, then release
        step(1, c3,   p3,   '0,    1'b1, 1'b1, C_BUSY, RUN, 16'd5,    16'd1);
        step(1, c3,   p3,   '0,    1'b1, 1'b1, C_BUSY, HLD, 16'd5,    16'd1);
        step(1, c3,   p3,   '0,    1'b1, 1'b1, C_BUSY, HLD, 16'd5,    16'd1);
        step(1, c3,   p3,   '0,    1'b1, 1'b0, C_RED,  HLD, 16'd5,    16'd1);
        step(1, '0,   '0,   '0,    1'b0, 1'b0, C_NONE, RUN, 16'd5,    16'd2);
        // HOLD drops into STALL when the hazard is still pending
        step(1, c3,   p3,   '0,    1'b0, 1'b1, C_BUSY, RUN, 16'd5,    16'd2);
        step(1, c3,   p3,   '0,    1'b0, 1'b0, C_HAZ,  HLD, 16'd5,    16'd2);
        step(1, '0,   '0,   '0,    1'b0, 1'b0, C_NONE, STL, 16'd6,    16'd2);
        step(1, '0,   '0,   '0,    1'b0, 1'b0, C_NONE, RUN, 16'd6,    16'd2);

        // unchecked hazard run bringing stall_cnt from 6 to 16'hFFFE
        @(posedge clk);
        #1;
        bus.IR_D = c3; bus.IR_E = p3; bus.IR_M = '0;
        repeat (65528 - 1) @(posedge clk);

        step(1, c3,   p3,   '0,    1'b0, 1'b0, C_HAZ,  STL, 16'hFFFE, 16'd2);
        step(1, c3,   p3,   '0,    1'b0, 1'b0, C_HAZ,  STL, 16'hFFFF, 16'd2);
        step(1, c3,   p3,   '0,    1'b0, 1'b0, C_HAZ,  STL, 16'hFFFF, 16'd2);
        // reset mid-stall clears immediately; release with the hazard still present
        step(0, c3,   p3,   '0,    1'b0, 1'b0, C_RSTH, RUN, 16'd0,    16'd0);
        step(1, c3,   p3,   '0,    1'b0, 1'b0, C_HAZ,  RUN, 16'd0,    16'd0);
        step(1, c3,   p3,   '0,    1'b0, 1'b0, C_HAZ,  STL, 16'd1,    16'd0);
        step(1, '0,   '0,   '0,    1'b0, 1'b0, C_NONE, STL, 16'd2,    16'd0);

        repeat (3) @(posedge clk);
        #1;
        cmp(vid, "queue_drained", 16'(exp_q.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
